regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A (ALU) and B (load unit).
Arbitration is round-robin with valid/ready handshakes, and the winning write is registered onto reg_write/rd/data with one cycle of latency.
A busy scoreboard tracks destinations with writes outstanding, so the issue stage can stall on read-after-write hazards.
The block sits between the execute/memory writeback paths and the register file.

Parameters:
DATA_W, 32, width of write data.
ADDR_W, 5, register address width.
NUM_REGS, 32, number of architectural registers (2**ADDR_W); register 0 is never written.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
a_valid  input  1  requester A has a write pending.
a_ready  output  1  A accepted this cycle (combinational grant).
a_rd  input  ADDR_W  A destination register.
a_data  input  DATA_W  A write data.
b_valid  input  1  requester B has a write pending.
b_ready  output  1  B accepted this cycle (combinational grant).
b_rd  input  ADDR_W  B destination register.
b_data  input  DATA_W  B write data.
reg_write  output  1  registered write enable to the register file.
wr_rd  output  ADDR_W  registered write address.
wr_data  output  DATA_W  registered write data.
alloc_valid  input  1  issue stage marks alloc_rd as having a write in flight.
alloc_rd  input  ADDR_W  register being allocated.
rs1  input  ADDR_W  read address 1 to check.
rs2  input  ADDR_W  read address 2 to check.
rs1_busy  output  1  rs1 has an outstanding write (combinational).
rs2_busy  output  1  rs2 has an outstanding write (combinational).

Behaviour:
Clock and reset:
- One clock, clk. reset_n is asynchronous and active-low.
- On reset: reg_write=0, wr_rd=0, wr_data=0, busy vector all 0, round-robin pointer set to prefer A.
- Reset asserted mid-operation discards any in-flight write; no reg_write pulse follows deassertion.

Arbitration (combinational):
- Only A valid: a_ready=1. Only B valid: b_ready=1. Neither valid: both ready=0.
- Both valid: grant the requester the pointer prefers.
- At most one ready per cycle. Ready never asserts without the matching valid.
- Pointer update: on each accepted transfer, the pointer moves to prefer the other requester. With no transfer, the pointer holds.
- Requesters hold valid, rd and data stable until ready. The arbiter does not assume this and latches only on the accepted cycle.

Write port (registered, 1-cycle latency):
- Transfer accepted at edge N: during cycle N+1, reg_write=1 and wr_rd/wr_data hold the granted rd/data.
- No transfer: reg_write=0; wr_rd/wr_data hold their last value.
- Granted rd==0: the handshake completes (ready=1) but reg_write stays 0 (write suppressed).
- Back-to-back transfers produce back-to-back reg_write cycles. Throughput is 1 write per cycle.

Scoreboard (busy[NUM_REGS-1:0]):
- Set: alloc_valid=1 with alloc_rd!=0 sets busy[alloc_rd] at the edge.
- Clear: reg_write=1 clears busy[wr_rd] at the edge ending that cycle, i.e. the same edge the register file captures the data.
- Result: busy drops in the first cycle in which the register file holds the new value.
- Set and clear on the same register at the same edge: set wins (a new producer was issued).
- Allocating an already-busy register leaves it busy; the first matching writeback clears it. The issue stage must stall instead of double-allocating.
- busy[0] is always 0.
- rsX_busy = busy[rsX], with no forwarding of same-cycle alloc.
- rs==0 always reads not busy.

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=0x12345678 for one cycle. Expect: a_ready=1 in that cycle; next cycle reg_write=1, wr_rd=5, wr_data=0x12345678; following cycle reg_write=0.
- A and B both valid for 4 cycles (A rd=1/2, B rd=3/4; data=rd). Expect: grants A,B,A,B; reg_write sequence 1,3,2,4; only one ready per cycle.
- Only B valid for 3 cycles, then both valid. Expect: B granted 3 times; the first contended cycle grants A.
- alloc_valid with alloc_rd=7; rs1=7. Expect: rs1_busy=1 from next cycle. Then B writes rd=7: rs1_busy stays 1 during the reg_write cycle and reads 0 the cycle after.
- A writes rd=0 with data 0xFFFFFFFF. Expect: a_ready=1, reg_write stays 0; alloc_rd=0 leaves rs1_busy(rs1=0)=0.
- Collision: reg_write=1 with wr_rd=9 in the same cycle as alloc_valid, alloc_rd=9. Expect: busy[9] stays 1.
- Reset asserted the cycle after a handshake. Expect: reg_write=0 and all busy bits 0 immediately (asynchronous), with no write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback request, register-file write and scoreboard bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              reg_write;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              alloc_valid;
  logic [ADDR_W-1:0] alloc_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;

  // Requesters, issue stage and register file side.
  modport master (
    output a_valid, a_rd, a_data,
    input  a_ready,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  reg_write, wr_rd, wr_data,
    output alloc_valid, alloc_rd, rs1, rs2,
    input  rs1_busy, rs2_busy
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_rd, a_data,
    output a_ready,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output reg_write, wr_rd, wr_data,
    input  alloc_valid, alloc_rd, rs1, rs2,
    output rs1_busy, rs2_busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter for the register-file write port with a
//               busy scoreboard for read-after-write hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  regfile_wb_arbiter_if.slave       bus
);

  typedef enum logic [0:0] {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } pref_t;

  localparam logic [ADDR_W-1:0] c_ZERO_RD = '0;

  pref_t               r_pref;
  pref_t               w_pref_nxt;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_rd;
  logic [DATA_W-1:0]   w_data;
  logic                w_do_write;

  logic                r_reg_write;
  logic [ADDR_W-1:0]   r_wr_rd;
  logic [DATA_W-1:0]   r_wr_data;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Grant and round-robin pointer advance.
  always_comb begin
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_pref_nxt = r_pref;
    if (bus.a_valid && (!bus.b_valid || r_pref == PREF_A)) begin
      w_grant_a = 1'b1;
    end else if (bus.b_valid) begin
      w_grant_b = 1'b1;
    end
    if (w_grant_a) begin
      w_pref_nxt = PREF_B;
    end else if (w_grant_b) begin
      w_pref_nxt = PREF_A;
    end
  end

  assign w_xfer     = w_grant_a | w_grant_b;
  assign w_rd       = w_grant_a ? bus.a_rd : bus.b_rd;
  assign w_data     = w_grant_a ? bus.a_data : bus.b_data;
  assign w_do_write = w_xfer && (w_rd != c_ZERO_RD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pref <= PREF_A;
    end else begin
      r_pref <= w_pref_nxt;
    end
  end

  // Writes to r0 still complete the handshake but never reach the port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg_write <= 1'b0;
      r_wr_rd     <= '0;
      r_wr_data   <= '0;
    end else begin
      r_reg_write <= w_do_write;
      if (w_do_write) begin
        r_wr_rd   <= w_rd;
        r_wr_data <= w_data;
      end
    end
  end

  // Clear on retire first so a same-edge allocation of that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_reg_write) begin
      w_busy_nxt[r_wr_rd] = 1'b0;
    end
    if (bus.alloc_valid && (bus.alloc_rd != c_ZERO_RD)) begin
      w_busy_nxt[bus.alloc_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.a_ready   = w_grant_a;
  assign bus.b_ready   = w_grant_b;
  assign bus.reg_write = r_reg_write;
  assign bus.wr_rd     = r_wr_rd;
  assign bus.wr_data   = r_wr_data;
  assign bus.rs1_busy  = r_busy[bus.rs1];
  assign bus.rs2_busy  = r_busy[bus.rs2];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed and randomized checks of regfile_wb_arbiter against
//               a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who the arbiter favours, the write sitting on the port, busy set.
  bit          m_prefer_b;
  bit          m_wr_en;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_wr_data;
  bit          m_busy [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prefer_b = 1'b0;
    m_wr_en    = 1'b0;
    m_wr_rd    = '0;
    m_wr_data  = '0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit bv, input logic [4:0] brd, input logic [31:0] bdat,
                       input bit alv, input logic [4:0] alrd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit          ga, gb;
    logic [4:0]  rd;
    logic [31:0] dat;
    bus.a_valid     = av;
    bus.a_rd        = ard;
    bus.a_data      = adat;
    bus.b_valid     = bv;
    bus.b_rd        = brd;
    bus.b_data      = bdat;
    bus.alloc_valid = alv;
    bus.alloc_rd    = alrd;
    bus.rs1         = r1;
    bus.rs2         = r2;
    #3;
    ga = av && (!bv || !m_prefer_b);
    gb = bv && !ga;
    check("a_ready", {63'd0, bus.a_ready}, {63'd0, ga});
    check("b_ready", {63'd0, bus.b_ready}, {63'd0, gb});
    check("reg_write", {63'd0, bus.reg_write}, {63'd0, m_wr_en});
    if (m_wr_en) begin
      check("wr_rd", {59'd0, bus.wr_rd}, {59'd0, m_wr_rd});
      check("wr_data", {32'd0, bus.wr_data}, {32'd0, m_wr_data});
    end
    check("rs1_busy", {63'd0, bus.rs1_busy}, {63'd0, (r1 != 0) && m_busy[r1]});
    check("rs2_busy", {63'd0, bus.rs2_busy}, {63'd0, (r2 != 0) && m_busy[r2]});
    @(posedge clk);
    if (m_wr_en) m_busy[m_wr_rd] = 1'b0;
    if (alv && alrd != 0) m_busy[alrd] = 1'b1;
    if (ga || gb) begin
      rd  = ga ? ard : brd;
      dat = ga ? adat : bdat;
      m_wr_en = (rd != 0);
      if (rd != 0) begin
        m_wr_rd   = rd;
        m_wr_data = dat;
      end
      m_prefer_b = ga;
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    bus.alloc_valid = 0; bus.alloc_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    model_reset();
    #2;
    check("rst_reg_write", {63'd0, bus.reg_write}, 64'd0);
    check("rst_wr_rd", {59'd0, bus.wr_rd}, 64'd0);
    check("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single A write.
    apply(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    check("first_wr_data", {32'd0, bus.wr_data}, 64'h12345678);
    idle(0);
    idle(0);

    // B alone three times, then contention.
    apply(0, 0, 0, 1, 10, 10, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 11, 11, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 12, 12, 0, 0, 0, 0);
    apply(1, 13, 13, 1, 14, 14, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 14, 14, 0, 0, 0, 0);
    idle(0);

    // Sustained contention: A 1/2, B 3/4.
    apply(1, 1, 1, 1, 3, 3, 0, 0, 0, 0);
    apply(1, 2, 2, 1, 3, 3, 0, 0, 0, 0);
    apply(1, 2, 2, 1, 4, 4, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 4, 4, 0, 0, 0, 0);
    idle(0);

    // Scoreboard set then clear through a B write to r7.
    apply(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7);
    apply(0, 0, 0, 1, 7, 32'hCAFE, 0, 0, 7, 0);
    check("busy_during_wr", {63'd0, bus.rs1_busy}, 64'd1);
    idle(7);
    check("busy_after_wr", {63'd0, bus.rs1_busy}, 64'd0);
    idle(7);

    // Writes and allocations to r0 are suppressed.
    apply(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    idle(0);
    idle(0);

    // Same-edge retire and allocate of r9 keeps it busy.
    apply(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    apply(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(9);
    check("collision_busy", {63'd0, bus.rs1_busy}, 64'd1);
    apply(0, 0, 0, 1, 9, 32'h98, 0, 0, 9, 0);
    idle(9);
    idle(9);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset in the cycle after a handshake.
    apply(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    apply(1, 12, 32'hABCD, 0, 0, 0, 1, 20, 0, 0);
    reset_n = 1'b0;
    #1;
    check("async_rst_reg_write", {63'd0, bus.reg_write}, 64'd0);
    check("async_rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
    for (int r = 1; r < 32; r++) begin
      bus.rs1 = 5'(r);
      #1;
      check("async_rst_busy", {63'd0, bus.rs1_busy}, 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    idle(12);
    idle(20);
    idle(0);
    apply(0, 0, 0, 1, 3, 3, 1, 3, 3, 0);
    apply(1, 4, 4, 1, 5, 5, 0, 0, 3, 0);
    idle(3);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
